// File: rtl/wb_arbiter_pkg.sv
// Writeback arbiter package: widths derived from macro_para.v, the FIFO entry
// layout and the load-extension helper shared by the arbiter.
package wb_arbiter_pkg;

`include "macro_para.v"

  localparam int unsigned AddrW   = `ADDR_BIT_NUM;
  localparam int unsigned DataW   = `RV_BIT_NUM;
  localparam int unsigned NumRegs = 1 << AddrW;

  localparam logic [2:0] F3Lb  = `LB_FUNCT3;
  localparam logic [2:0] F3Lh  = `LH_FUNCT3;
  localparam logic [2:0] F3Lw  = `LW_FUNCT3;
  localparam logic [2:0] F3Lbu = `LBU_FUNCT3;
  localparam logic [2:0] F3Lhu = `LHU_FUNCT3;

  // rd sits in the MSBs so {rd, data} concatenations map directly onto it.
  typedef struct packed {
    logic [AddrW-1:0] rd;
    logic [DataW-1:0] data;
  } wb_entry_t;

  localparam int unsigned EntryW = $bits(wb_entry_t);

  // Select byte/half by offset and extend; unknown funct3 passes the word.
  function automatic logic [DataW-1:0] load_ext(input logic [2:0]       funct3,
                                                input logic [1:0]       off,
                                                input logic [DataW-1:0] word);
    logic [7:0]       b;
    logic [15:0]      h;
    logic [DataW-1:0] res;
    b = 8'(word >> {off, 3'b000});
    h = 16'(word >> {off[1], 4'b0000});
    case (funct3)
      F3Lb:    res = {{(DataW - 8){b[7]}}, b};
      F3Lbu:   res = {{(DataW - 8){1'b0}}, b};
      F3Lh:    res = {{(DataW - 16){h[15]}}, h};
      F3Lhu:   res = {{(DataW - 16){1'b0}}, h};
      default: res = word;
    endcase
    load_ext = res;
  endfunction

endpackage

// File: rtl/macro_para.v
// Shared core-wide constants: register-address width, datapath width and the
// RV32I load funct3 encodings. Included wherever these values are needed.
`ifndef MACRO_PARA_V
`define MACRO_PARA_V

`define ADDR_BIT_NUM 5
`define RV_BIT_NUM   32

`define LB_FUNCT3  3'b000
`define LH_FUNCT3  3'b001
`define LW_FUNCT3  3'b010
`define LBU_FUNCT3 3'b100
`define LHU_FUNCT3 3'b101

`endif

// File: rtl/wb_fifo2.sv
// Two-entry FIFO holding ALU results awaiting the register-file write port.
// Ports: clk/rst_n; push + push_data enqueue; pop dequeues the head;
// count (0..2); head = oldest entry; second = younger entry (valid at count 2).
module wb_fifo2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [Width-1:0] head,
  output logic [Width-1:0] second
);

  logic [Width-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          slot0_d = push_data;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          slot1_d = push_data;
          count_d = 2'd2;
        end
      end
      2'b01: begin
        if (count_q != 2'd0) begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
      end
      2'b11: begin
        // Count stays put; at count 2 the pop frees the slot for the push.
        if (count_q == 2'd0) begin
          slot0_d = push_data;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          slot0_d = push_data;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign head   = slot0_q;
  assign second = slot1_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results (buffered in a 2-entry FIFO) and load
// results onto a single registered register-file write port, extends loads,
// and tracks outstanding load destinations for hazard queries.
// Ports: alu_* / mem_* valid-ready result inputs; issue_en/issue_rd mark a
// load destination pending; rs1/rs2_addr -> rs1/rs2_busy hazard outputs;
// rf_wen/rf_waddr/rf_wdata registered write port.
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [AddrW-1:0] alu_rd,
  input  logic [DataW-1:0] alu_data,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [AddrW-1:0] mem_rd,
  input  logic [DataW-1:0] mem_rdata,
  input  logic [2:0]       mem_funct3,
  input  logic [1:0]       mem_off,
  input  logic             issue_en,
  input  logic [AddrW-1:0] issue_rd,
  input  logic [AddrW-1:0] rs1_addr,
  input  logic [AddrW-1:0] rs2_addr,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rf_wen,
  output logic [AddrW-1:0] rf_waddr,
  output logic [DataW-1:0] rf_wdata
);

  logic [1:0]         fifo_count;
  wb_entry_t          fifo_head, fifo_second, win;
  logic               fifo_full, fifo_push, fifo_pop, grant_mem;
  logic [NumRegs-1:0] pend_q, pend_d, pend_set, pend_clr;
  logic               rf_wen_q;
  logic [AddrW-1:0]   rf_waddr_q;
  logic [DataW-1:0]   rf_wdata_q;

  wb_fifo2 #(
    .Width(EntryW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_data({alu_rd, alu_data}),
    .pop      (fifo_pop),
    .count    (fifo_count),
    .head     (fifo_head),
    .second   (fifo_second)
  );

  // A full FIFO always wins so the ALU can never be starved; otherwise loads
  // go first. mem_ready is gated by reset so it is 0 while rst_n is low.
  always_comb begin
    fifo_full = (fifo_count == 2'd2);
    grant_mem = rst_n && mem_valid && !fifo_full;
    fifo_pop  = fifo_full || (!mem_valid && (fifo_count != 2'd0));
    fifo_push = alu_valid && !fifo_full;
    if (grant_mem) begin
      win.rd   = mem_rd;
      win.data = load_ext(mem_funct3, mem_off, mem_rdata);
    end else begin
      win = fifo_head;
    end
  end

  assign alu_ready = !fifo_full;
  assign mem_ready = grant_mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      // x0 results are consumed but never written.
      rf_wen_q <= (grant_mem || fifo_pop) && (win.rd != '0);
      if (grant_mem || fifo_pop) begin
        rf_waddr_q <= win.rd;
        rf_wdata_q <= win.data;
      end
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // Set is applied after clear so a same-cycle issue of the retiring rd wins.
  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (issue_en && (issue_rd != '0)) pend_set[issue_rd] = 1'b1;
    if (grant_mem) pend_clr[mem_rd] = 1'b1;
    pend_d = (pend_q & ~pend_clr) | pend_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign rs1_busy = (rs1_addr != '0) &&
                    (pend_q[rs1_addr] ||
                     ((fifo_count != 2'd0) && (fifo_head.rd == rs1_addr)) ||
                     (fifo_full && (fifo_second.rd == rs1_addr)) ||
                     (rf_wen_q && (rf_waddr_q == rs1_addr)));

  assign rs2_busy = (rs2_addr != '0) &&
                    (pend_q[rs2_addr] ||
                     ((fifo_count != 2'd0) && (fifo_head.rd == rs2_addr)) ||
                     (fifo_full && (fifo_second.rd == rs2_addr)) ||
                     (rf_wen_q && (rf_waddr_q == rs2_addr)));

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter. Inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge. Expected register-file
// writes are queued when the stimulus is driven and popped by the monitor.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             alu_valid = 1'b0;
  logic             alu_ready;
  logic [AddrW-1:0] alu_rd = '0;
  logic [DataW-1:0] alu_data = '0;
  logic             mem_valid = 1'b0;
  logic             mem_ready;
  logic [AddrW-1:0] mem_rd = '0;
  logic [DataW-1:0] mem_rdata = '0;
  logic [2:0]       mem_funct3 = '0;
  logic [1:0]       mem_off = '0;
  logic             issue_en = 1'b0;
  logic [AddrW-1:0] issue_rd = '0;
  logic [AddrW-1:0] rs1_addr = '0;
  logic [AddrW-1:0] rs2_addr = '0;
  logic             rs1_busy, rs2_busy;
  logic             rf_wen;
  logic [AddrW-1:0] rf_waddr;
  logic [DataW-1:0] rf_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [AddrW-1:0] rd;
    logic [DataW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  typedef struct packed {
    logic [2:0]       f3;
    logic [1:0]       off;
    logic [DataW-1:0] word;
    logic [AddrW-1:0] rd;
    logic [DataW-1:0] want;
  } ld_t;

  ld_t ld_tab[10] = '{
    '{3'b000, 2'd3, 32'h8000_0000, 5'd5,  32'hFFFF_FF80},
    '{3'b100, 2'd3, 32'h8000_0000, 5'd5,  32'h0000_0080},
    '{3'b001, 2'd2, 32'h8001_1234, 5'd6,  32'hFFFF_8001},
    '{3'b101, 2'd0, 32'h8001_1234, 5'd6,  32'h0000_1234},
    '{3'b101, 2'd2, 32'h8001_1234, 5'd6,  32'h0000_8001},
    '{3'b010, 2'd0, 32'hDEAD_BEEF, 5'd8,  32'hDEAD_BEEF},
    '{3'b011, 2'd1, 32'hDEAD_BEEF, 5'd8,  32'hDEAD_BEEF},
    '{3'b000, 2'd1, 32'h0000_7F00, 5'd9,  32'h0000_007F},
    '{3'b001, 2'd0, 32'h1234_F00F, 5'd9,  32'hFFFF_F00F},
    '{3'b100, 2'd2, 32'h00AB_0000, 5'd10, 32'h0000_00AB}
  };

  wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_funct3(mem_funct3),
    .mem_off   (mem_off),
    .issue_en  (issue_en),
    .issue_rd  (issue_rd),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1);
  end

  // Scoreboard monitor: every write on the rf port must match the queue head.
  always @(negedge clk) begin
    if (rf_wen === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rf_write_unexpected: got waddr=%0d wdata=%h, required no write",
                 rf_waddr, rf_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rf_waddr !== e.rd || rf_wdata !== e.data) begin
          n_fail++;
          $display("FAIL rf_write: got waddr=%0d wdata=%h, required waddr=%0d wdata=%h",
                   rf_waddr, rf_wdata, e.rd, e.data);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [AddrW-1:0] rd, input logic [DataW-1:0] data);
    exp_q.push_back('{rd: rd, data: data});
  endtask

  task automatic test_reset();
    mem_valid = 1'b1;
    rs1_addr  = 5'd5;
    repeat (2) @(negedge clk);
    n_checks++;
    if (rf_wen !== 1'b0) begin
      n_fail++; $display("FAIL reset_rf_wen: got %b, required 0", rf_wen);
    end
    n_checks++;
    if (rf_waddr !== '0 || rf_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_rf_addr_data: got %0d/%h, required 0/0", rf_waddr, rf_wdata);
    end
    n_checks++;
    if (alu_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_alu_ready: got %b, required 1", alu_ready);
    end
    n_checks++;
    if (mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem_ready: got %b, required 0", mem_ready);
    end
    n_checks++;
    if (rs1_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_rs1_busy: got %b, required 0", rs1_busy);
    end
    mem_valid = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_load_ext();
    for (int i = 0; i < 10; i++) begin
      mem_valid  = 1'b1;
      mem_funct3 = ld_tab[i].f3;
      mem_off    = ld_tab[i].off;
      mem_rdata  = ld_tab[i].word;
      mem_rd     = ld_tab[i].rd;
      expect_write(ld_tab[i].rd, ld_tab[i].want);
      @(negedge clk);
      n_checks++;
      if (mem_ready !== 1'b1) begin
        n_fail++; $display("FAIL load_mem_ready[%0d]: got %b, required 1", i, mem_ready);
      end
      next_cycle();
      mem_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rf_wen !== 1'b1) begin
        n_fail++; $display("FAIL load_latency[%0d]: rf_wen got %b, required 1", i, rf_wen);
      end
      next_cycle();
    end
  endtask

  task automatic test_contention();
    mem_funct3 = F3Lw;
    mem_off    = 2'd0;
    // Cycle 0: both valid, FIFO empty -> mem granted, ALU rd=1 pushed.
    mem_valid = 1'b1; mem_rd = 5'd10; mem_rdata = 32'hA000_0010;
    alu_valid = 1'b1; alu_rd = 5'd1;  alu_data  = 32'hD000_0001;
    expect_write(5'd10, 32'hA000_0010);
    @(negedge clk);
    n_checks++;
    if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cont_c0_ready: got mem=%b alu=%b, required 1/1", mem_ready, alu_ready);
    end
    next_cycle();
    // Cycle 1: count 1 -> mem still wins, ALU rd=2 pushed, FIFO becomes full.
    mem_rd = 5'd11; mem_rdata = 32'hA000_0011;
    alu_rd = 5'd2;  alu_data  = 32'hD000_0002;
    expect_write(5'd11, 32'hA000_0011);
    @(negedge clk);
    n_checks++;
    if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cont_c1_ready: got mem=%b alu=%b, required 1/1", mem_ready, alu_ready);
    end
    next_cycle();
    // Cycle 2: FIFO full -> head (rd=1) wins, mem stalls.
    alu_valid = 1'b0;
    mem_rd = 5'd12; mem_rdata = 32'hA000_0012;
    expect_write(5'd1, 32'hD000_0001);
    @(negedge clk);
    n_checks++;
    if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_full_ready: got alu=%b mem=%b, required 0/0", alu_ready, mem_ready);
    end
    next_cycle();
    // Cycle 3: count 1 again -> mem rd=12 accepted.
    expect_write(5'd12, 32'hA000_0012);
    @(negedge clk);
    n_checks++;
    if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cont_c3_ready: got mem=%b alu=%b, required 1/1", mem_ready, alu_ready);
    end
    next_cycle();
    // Cycle 4: mem idle -> FIFO head rd=2 drains.
    mem_valid = 1'b0;
    expect_write(5'd2, 32'hD000_0002);
    @(negedge clk);
    n_checks++;
    if (mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL cont_c4_mem_ready: got %b, required 0", mem_ready);
    end
    repeat (2) next_cycle();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL cont_drain: got %0d pending writes, required 0", exp_q.size());
    end
  endtask

  task automatic test_x0();
    rs1_addr = 5'd3;
    rs2_addr = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_0055;
    @(negedge clk);
    n_checks++;
    if (alu_ready !== 1'b1) begin
      n_fail++; $display("FAIL x0_alu_ready: got %b, required 1", alu_ready);
    end
    next_cycle();
    // rd=0 entry is now the FIFO head; rs2=0 must still read not-busy.
    alu_rd = 5'd3; alu_data = 32'h0000_0033;
    expect_write(5'd3, 32'h0000_0033);
    @(negedge clk);
    n_checks++;
    if (rs2_busy !== 1'b0) begin
      n_fail++; $display("FAIL x0_rs2_busy_fifo: got %b, required 0", rs2_busy);
    end
    next_cycle();
    alu_rd = 5'd4; alu_data = 32'h0000_0044;
    expect_write(5'd4, 32'h0000_0044);
    @(negedge clk);
    n_checks++;
    if (rf_wen !== 1'b0) begin
      n_fail++; $display("FAIL x0_no_wen: got %b, required 0", rf_wen);
    end
    n_checks++;
    if (rs1_busy !== 1'b1) begin
      n_fail++; $display("FAIL x0_rs1_busy_fifo_entry: got %b, required 1", rs1_busy);
    end
    next_cycle();
    alu_valid = 1'b0;
    issue_en = 1'b1; issue_rd = 5'd0;
    @(negedge clk);
    n_checks++;
    if (rs1_busy !== 1'b1) begin
      n_fail++; $display("FAIL x0_rs1_busy_rf_port: got %b, required 1", rs1_busy);
    end
    next_cycle();
    issue_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rs2_busy !== 1'b0) begin
      n_fail++; $display("FAIL x0_rs2_busy_issue: got %b, required 0", rs2_busy);
    end
    repeat (2) next_cycle();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL x0_drain: got %0d pending writes, required 0", exp_q.size());
    end
  endtask

  task automatic test_scoreboard();
    rs1_addr = 5'd7;
    rs2_addr = 5'd7;
    mem_funct3 = F3Lw;
    mem_off    = 2'd0;
    issue_en = 1'b1; issue_rd = 5'd7;
    @(negedge clk);
    n_checks++;
    if (rs1_busy !== 1'b0) begin
      n_fail++; $display("FAIL sb_before_issue: got %b, required 0", rs1_busy);
    end
    next_cycle();
    issue_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_pending: got rs1=%b rs2=%b, required 1/1", rs1_busy, rs2_busy);
    end
    repeat (2) next_cycle();
    mem_valid = 1'b1; mem_rd = 5'd7; mem_rdata = 32'h0000_0077;
    expect_write(5'd7, 32'h0000_0077);
    @(negedge clk);
    n_checks++;
    if (rs1_busy !== 1'b1) begin
      n_fail++; $display("FAIL sb_busy_grant: got %b, required 1", rs1_busy);
    end
    next_cycle();
    mem_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rs1_busy !== 1'b1) begin
      n_fail++; $display("FAIL sb_busy_retire: got %b, required 1", rs1_busy);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (rs1_busy !== 1'b0) begin
      n_fail++; $display("FAIL sb_cleared: got %b, required 0", rs1_busy);
    end
    next_cycle();
    issue_en = 1'b1; issue_rd = 5'd7;
    next_cycle();
    // Re-issue and retire rd 7 in the same cycle: the bit must stay set.
    mem_valid = 1'b1; mem_rd = 5'd7; mem_rdata = 32'h0000_0078;
    expect_write(5'd7, 32'h0000_0078);
    next_cycle();
    issue_en = 1'b0;
    mem_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (rs1_busy !== 1'b1 || rf_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_set_clear_same: got busy=%b rf_wen=%b, required 1/0", rs1_busy, rf_wen);
    end
    next_cycle();
    mem_valid = 1'b1; mem_rdata = 32'h0000_0079;
    expect_write(5'd7, 32'h0000_0079);
    next_cycle();
    mem_valid = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    n_checks++;
    if (rs1_busy !== 1'b0) begin
      n_fail++; $display("FAIL sb_final_clear: got %b, required 0", rs1_busy);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    rs1_addr = 5'd9;
    rs2_addr = 5'd20;
    mem_funct3 = F3Lw;
    // Keep mem busy with x0 loads so both ALU pushes pile up in the FIFO.
    issue_en = 1'b1; issue_rd = 5'd9;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_rdata = 32'h0;
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h0000_00A0;
    next_cycle();
    issue_en = 1'b0;
    alu_rd = 5'd21; alu_data = 32'h0000_00A1;
    next_cycle();
    alu_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (alu_ready !== 1'b0 || rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_full: got alu_ready=%b rs1=%b rs2=%b, required 0/1/1",
               alu_ready, rs1_busy, rs2_busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (alu_ready !== 1'b1 || rf_wen !== 1'b0 || mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_ctrl: got alu_ready=%b rf_wen=%b mem_ready=%b, required 1/0/0",
               alu_ready, rf_wen, mem_ready);
    end
    n_checks++;
    if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_busy: got rs1=%b rs2=%b, required 0/0", rs1_busy, rs2_busy);
    end
    exp_q.delete();
    next_cycle();
    mem_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rf_wen !== 1'b0) begin
      n_fail++; $display("FAIL rmid_first_cycle: got rf_wen=%b, required 0", rf_wen);
    end
    repeat (3) next_cycle();
    @(negedge clk);
    n_checks++;
    if (rs2_busy !== 1'b0 || alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_fifo_empty: got rs2=%b alu_ready=%b, required 0/1",
               rs2_busy, alu_ready);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_contention();
    test_x0();
    test_scoreboard();
    test_reset_mid();
    repeat (3) next_cycle();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL final_drain: got %0d pending writes, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 clk  in  1  rising-edge clock, single clock domain.
REQ-002 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 alu_valid/alu_ready  in/out  1/1  single-cycle ALU result handshake.
REQ-004 alu_rd  in  ADDR_BIT_NUM  ALU destination register.
REQ-005 alu_data  in  RV_BIT_NUM  ALU result.
REQ-006 mem_valid/mem_ready  in/out  1/1  load result handshake.
REQ-007 mem_rd  in  ADDR_BIT_NUM  load destination register.
REQ-008 mem_rdata  in  RV_BIT_NUM  raw aligned memory word.
REQ-009 mem_funct3  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101.
REQ-010 mem_off  in  2  byte offset within the word.
REQ-011 issue_en, issue_rd  in  1, ADDR_BIT_NUM  load issued; marks issue_rd pending.
REQ-012 rs1_addr, rs2_addr  in  ADDR_BIT_NUM  hazard query addresses.
REQ-013 rs1_busy, rs2_busy  out  1  queried register has an outstanding write.
REQ-014 rf_wen, rf_waddr, rf_wdata  out  1, ADDR_BIT_NUM, RV_BIT_NUM  register-file write port (drives wen/waddr/wdata).

Function
REQ-015 A transfer SHALL occur on a port when valid and ready are both high at a rising edge.
REQ-016 ALU results SHALL enter a 2-entry FIFO; alu_ready SHALL be high iff the FIFO count is less than 2 (count 2 means full).
REQ-017 Arbitration each cycle: if FIFO count = 2, the FIFO head wins; otherwise a valid mem result wins; otherwise a non-empty FIFO head wins.
REQ-018 mem_ready SHALL be high iff mem is granted by REQ-017 (combinational on mem_valid and FIFO count).
REQ-019 A granted result SHALL appear on rf_wen/rf_waddr/rf_wdata exactly one cycle after the grant edge; the outputs are registered.
REQ-020 rf_wen SHALL be 0 for any result whose rd = 0; that result is still consumed.
REQ-021 Load extension, byte = mem_rdata[8*off+7:8*off], half = mem_rdata[16*off[1]+15:16*off[1]]: LB sign-extends the byte; LBU zero-extends it; LH sign-extends the half; LHU zero-extends it; LW passes the word. Any other funct3 SHALL pass the word unchanged.
REQ-022 FIFO push and pop in the same cycle SHALL leave the count unchanged, including at count 2 (pop frees the slot); push at full is impossible by REQ-016.
REQ-023 Scoreboard: 32-bit pending vector; issue_en sets bit issue_rd (ignored for rd=0); a granted mem result clears bit mem_rd.
REQ-024 Simultaneous set and clear of the same bit SHALL leave it set.
REQ-025 rsN_busy SHALL be combinational and high when rsN != 0 and any of the following holds:
- the scoreboard bit for rsN is set;
- any valid FIFO entry has rd = rsN;
- rf_wen = 1 with rf_waddr = rsN.
REQ-026 rsN_busy SHALL be 0 for rsN = 0.
REQ-027 A FIFO entry SHALL be popped only when granted; FIFO order SHALL be preserved.

Reset
REQ-028 While rst_n = 0: FIFO count 0; scoreboard 0; rf_wen 0; rf_waddr 0; rf_wdata 0; alu_ready 1; mem_ready 0.
REQ-029 Reset mid-operation SHALL discard FIFO contents and pending bits; no rf write SHALL occur in the first cycle after deassertion.

Structure
REQ-030 ADDR_BIT_NUM, RV_BIT_NUM and the load funct3 encodings SHALL come from the shared macro_para.v include.
REQ-031 The 2-entry ALU FIFO SHALL be a sub-module named wb_fifo2 (parameterised width; push/pop/count/head).
REQ-032 Extension, arbitration and scoreboard logic SHALL live in wb_arbiter.

Verification
REQ-033 Load extension: LB, off=3, rdata=0x80_00_00_00, rd=5 -> next cycle rf_wen=1, waddr=5, wdata=0xFFFFFF80. LBU, same inputs -> wdata=0x00000080.
REQ-034 LH extension: LH, off=2, rdata=0x8001_1234 -> wdata=0xFFFF8001.
REQ-035 Contention: mem_valid held 4 cycles, ALU pushes rd=1 and rd=2 -> mem wins until the FIFO is full, then rd=1 is written; alu_ready=0 during the full cycle; writes stay in order.
REQ-036 Scoreboard: issue_en rd=7, then query rs1=7 -> busy=1 until the cycle after the mem write of rd 7 retires from the rf port; set and clear of rd 7 in the same cycle -> stays busy.
REQ-037 x0 handling: ALU result rd=0 -> consumed with rf_wen=0; rs2_addr=0 -> rs2_busy=0 always.
REQ-038 Reset mid-operation: rst_n pulsed low with FIFO full -> count 0, alu_ready=1, rf_wen=0, all busy=0 immediately.
